// File: rtl/user_pkg.sv
// Register map, field positions and OBI subordinate types shared by the
// accelerator control block and its run controller.
package user_pkg;

  localparam int unsigned AidWidth = 4;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  // Word index of each register, i.e. byte offset [4:2].
  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_STATUS = 3'd1,
    REG_BASE   = 3'd2,
    REG_LEN    = 3'd3,
    REG_RUNS   = 3'd4,
    REG_CYCLES = 3'd5
  } reg_idx_e;

  localparam int unsigned CtrlStartBit     = 0;
  localparam int unsigned CtrlIrqEnBit     = 1;
  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusDoneBit    = 1;
  localparam int unsigned StatusMatchBit   = 2;
  localparam int unsigned StatusOverrunBit = 3;

  localparam logic [31:0] ErrRdata = 32'hBADC_AB1E;

  typedef enum logic {
    RUN_IDLE = 1'b0,
    RUN_BUSY = 1'b1
  } run_state_e;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/accel_ctrl_regs_if.sv
// OBI subordinate port bundle: request from the core, response from the block.
interface accel_ctrl_regs_if;
  import user_pkg::*;

  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/accel_run_ctrl.sv
// Run controller: BUSY state, run-cycle counter, completed-run count and the
// start/completion/overrun decisions for one accelerator.
module accel_run_ctrl
  import user_pkg::*;
#(
  parameter int unsigned CycleCntWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_req_i,
  input  logic                     len_zero_i,
  input  logic                     done_i,
  input  logic                     match_i,
  output logic                     busy_o,
  output logic                     start_o,
  output logic                     complete_o,
  output logic                     match_o,
  output logic                     overrun_o,
  output logic [15:0]              runs_o,
  output logic [CycleCntWidth-1:0] cycles_o
);

  localparam logic [CycleCntWidth-1:0] CntMax = '1;

  run_state_e               state_q;
  logic                     start_q;
  logic [CycleCntWidth-1:0] cnt_q;
  logic [CycleCntWidth-1:0] cycles_q;
  logic [15:0]              runs_q;

  logic                     finish;
  logic                     free;
  logic                     launch;
  logic                     zero_start;
  logic [CycleCntWidth-1:0] cnt_inc;

  // A completion in the same cycle frees the engine before START is judged.
  assign finish     = done_i && (state_q == RUN_BUSY);
  assign free       = (state_q == RUN_IDLE) || finish;
  assign launch     = start_req_i && free && !len_zero_i;
  assign zero_start = start_req_i && free && len_zero_i;
  assign cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + CycleCntWidth'(1);

  assign busy_o     = (state_q == RUN_BUSY);
  assign start_o    = start_q;
  assign complete_o = finish || zero_start;
  assign match_o    = finish && match_i && !zero_start;
  assign overrun_o  = start_req_i && !free;
  assign runs_o     = runs_q;
  assign cycles_o   = cycles_q;

  // NOTE: state is written with <= so every branch sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN_IDLE;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      cycles_q <= '0;
      runs_q   <= '0;
    end else begin
      start_q <= launch;
      if (launch) begin
        state_q <= RUN_BUSY;
        cnt_q   <= '0;
      end else if (finish) begin
        state_q <= RUN_IDLE;
      end else if (state_q == RUN_BUSY) begin
        cnt_q <= cnt_inc;
      end
      if (finish) begin
        cycles_q <= cnt_inc;
        runs_q   <= runs_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/accel_ctrl_regs.sv
// OBI-mapped control/status registers for a single accelerator; the run
// bookkeeping lives in accel_run_ctrl.
module accel_ctrl_regs
  import user_pkg::*;
#(
  parameter type         obi_req_t     = sbr_obi_req_t,
  parameter type         obi_rsp_t     = sbr_obi_rsp_t,
  parameter int unsigned CycleCntWidth = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic        start_o,
  output logic [31:0] cfg_addr_o,
  output logic [15:0] cfg_len_o,
  input  logic        done_i,
  input  logic        match_i,
  output logic        irq_o
);

  obi_rsp_t    rsp_q;
  logic        irq_en_q;
  logic [31:0] base_q;
  logic [15:0] len_q;
  logic        done_q;
  logic        match_q;
  logic        overrun_q;

  logic [2:0]  reg_idx;
  logic        wr;
  logic        lane0_wr;
  logic        start_req;
  logic        done_clr;
  logic        ovr_clr;
  logic [31:0] base_merge;
  logic [31:0] len_merge;
  logic [31:0] rdata_d;
  logic        err_d;

  logic                     busy;
  logic                     run_complete;
  logic                     run_match;
  logic                     run_overrun;
  logic [15:0]              runs;
  logic [CycleCntWidth-1:0] cycles;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0]};

  assign reg_idx    = obi_req_i.a.addr[4:2];
  assign wr         = obi_req_i.req && obi_req_i.a.we;
  assign lane0_wr   = wr && obi_req_i.a.be[0];
  assign start_req  = lane0_wr && (reg_idx == REG_CTRL) && obi_req_i.a.wdata[CtrlStartBit];
  assign done_clr   = lane0_wr && (reg_idx == REG_STATUS) && obi_req_i.a.wdata[StatusDoneBit];
  assign ovr_clr    = lane0_wr && (reg_idx == REG_STATUS) && obi_req_i.a.wdata[StatusOverrunBit];
  assign base_merge = apply_be(base_q, obi_req_i.a.wdata, obi_req_i.a.be);
  assign len_merge  = apply_be({16'h0, len_q}, obi_req_i.a.wdata, obi_req_i.a.be);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    case (reg_idx)
      REG_CTRL:   rdata_d[CtrlIrqEnBit] = irq_en_q;
      REG_STATUS: begin
        rdata_d[StatusBusyBit]    = busy;
        rdata_d[StatusDoneBit]    = done_q;
        rdata_d[StatusMatchBit]   = match_q;
        rdata_d[StatusOverrunBit] = overrun_q;
      end
      REG_BASE:   rdata_d = base_q;
      REG_LEN:    rdata_d = {16'h0, len_q};
      REG_RUNS:   rdata_d = {16'h0, runs};
      REG_CYCLES: rdata_d = 32'(cycles);
      default: begin
        rdata_d = ErrRdata;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_q     <= '0;
      irq_en_q  <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rsp_q.rvalid  <= obi_req_i.req;
      rsp_q.r.rid   <= obi_req_i.a.aid;
      rsp_q.r.rdata <= rdata_d;
      rsp_q.r.err   <= err_d;
      if (lane0_wr && (reg_idx == REG_CTRL)) irq_en_q <= obi_req_i.a.wdata[CtrlIrqEnBit];
      if (wr && (reg_idx == REG_BASE)) base_q <= {base_merge[31:2], 2'b00};
      if (wr && (reg_idx == REG_LEN))  len_q  <= len_merge[15:0];
      // A completion in the same cycle as a DONE clear leaves DONE set.
      if (run_complete) begin
        done_q  <= 1'b1;
        match_q <= run_match;
      end else if (done_clr) begin
        done_q  <= 1'b0;
        match_q <= 1'b0;
      end
      if (run_overrun)  overrun_q <= 1'b1;
      else if (ovr_clr) overrun_q <= 1'b0;
    end
  end

  always_comb begin
    obi_rsp_o     = rsp_q;
    obi_rsp_o.gnt = 1'b1;
  end

  assign cfg_addr_o = base_q;
  assign cfg_len_o  = len_q;
  assign irq_o      = irq_en_q && done_q;

  accel_run_ctrl #(
    .CycleCntWidth(CycleCntWidth)
  ) u_run_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_req_i (start_req),
    .len_zero_i  (len_q == 16'h0),
    .done_i      (done_i),
    .match_i     (match_i),
    .busy_o      (busy),
    .start_o     (start_o),
    .complete_o  (run_complete),
    .match_o     (run_match),
    .overrun_o   (run_overrun),
    .runs_o      (runs),
    .cycles_o    (cycles)
  );

endmodule

// File: tb/tb_accel_ctrl_regs.sv
// Scoreboard bench for accel_ctrl_regs: a cycle-level register/run model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_accel_ctrl_regs;
  import user_pkg::*;

  localparam int unsigned CW     = 32;
  localparam longint      CntMax = (longint'(1) << CW) - 1;

  logic        clk;
  logic        rst_i;
  logic        start_o;
  logic [31:0] cfg_addr_o;
  logic [15:0] cfg_len_o;
  logic        done_i;
  logic        match_i;
  logic        irq_o;

  accel_ctrl_regs_if bus ();

  accel_ctrl_regs #(.CycleCntWidth(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .obi_req_i  (bus.req),
    .obi_rsp_o  (bus.rsp),
    .start_o    (start_o),
    .cfg_addr_o (cfg_addr_o),
    .cfg_len_o  (cfg_len_o),
    .done_i     (done_i),
    .match_i    (match_i),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rvalid;
    logic [3:0]  rid;
    bit          err;
    bit          chk_rdata;
    logic [31:0] rdata;
    bit          start;
    bit          irq;
    logic [31:0] cfg_addr;
    logic [15:0] cfg_len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: software-visible registers plus the run in flight.
  bit          m_irq_en, m_done, m_match, m_overrun, m_busy;
  logic [31:0] m_base;
  logic [15:0] m_len, m_runs;
  longint      m_cycles, m_edge, m_start_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_irq_en = 0; m_done = 0; m_match = 0; m_overrun = 0; m_busy = 0;
    m_base = '0; m_len = '0; m_runs = '0; m_cycles = 0; m_start_edge = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, queue the outputs expected after the edge.
  task automatic step(input bit rst, input bit req, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input bit dn, input bit mt);
    exp_t        e;
    logic [31:0] mask, tmp;
    logic [3:0]  aid;
    int          idx;
    bit          started;
    longint      d;
    aid     = 4'($urandom());
    started = 0;
    @(negedge clk);
    rst_i           = rst;
    bus.req.req     = req;
    bus.req.a.addr  = addr;
    bus.req.a.we    = we;
    bus.req.a.be    = be;
    bus.req.a.wdata = wdata;
    bus.req.a.aid   = aid;
    done_i          = dn;
    match_i         = mt;
    m_edge++;
    e = '{default: '0};
    if (rst) begin
      model_reset();
    end else begin
      idx  = int'(addr[4:2]);
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (req) begin
        e.rvalid    = 1;
        e.rid       = aid;
        e.err       = (idx >= 6);
        e.chk_rdata = !we || (idx >= 6);
        case (idx)
          0:       e.rdata = {30'h0, m_irq_en, 1'b0};
          1:       e.rdata = {28'h0, m_overrun, m_match, m_done, m_busy};
          2:       e.rdata = m_base;
          3:       e.rdata = {16'h0, m_len};
          4:       e.rdata = {16'h0, m_runs};
          5:       e.rdata = 32'(m_cycles);
          default: e.rdata = 32'hBADC_AB1E;
        endcase
      end
      // Clear first so a completion in the same cycle wins.
      if (req && we && idx == 1 && be[0]) begin
        if (wdata[1]) begin m_done = 0; m_match = 0; end
        if (wdata[3]) m_overrun = 0;
      end
      if (dn && m_busy) begin
        d = m_edge - m_start_edge;
        if (d > CntMax) d = CntMax;
        m_busy = 0; m_done = 1; m_match = mt; m_cycles = d; m_runs = m_runs + 16'd1;
      end
      if (req && we) begin
        case (idx)
          0: if (be[0]) begin
            m_irq_en = wdata[1];
            if (wdata[0]) begin
              if (m_busy) m_overrun = 1;
              else if (m_len != 0) begin m_busy = 1; m_start_edge = m_edge; started = 1; end
              else begin m_done = 1; m_match = 0; end
            end
          end
          2: m_base = ((m_base & ~mask) | (wdata & mask)) & 32'hFFFF_FFFC;
          3: begin
            tmp   = ({16'h0, m_len} & ~mask) | (wdata & mask);
            m_len = tmp[15:0];
          end
          default: ;
        endcase
      end
    end
    e.start    = started;
    e.irq      = m_irq_en && m_done;
    e.cfg_addr = m_base;
    e.cfg_len  = m_len;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF,
                    input bit dn = 0, input bit mt = 0);
    step(0, 1, 1, a, d, be, dn, mt);
  endtask

  task automatic rd(input logic [31:0] a, input bit dn = 0, input bit mt = 0);
    step(0, 1, 0, a, $urandom(), 4'($urandom()), dn, mt);
  endtask

  task automatic idle(input int n, input bit dn = 0, input bit mt = 0);
    for (int i = 0; i < n; i++) step(0, 0, 0, $urandom(), $urandom(), 4'($urandom()), dn, mt);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, '0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("gnt", 32'(bus.rsp.gnt), 32'd1);
      if (exp_q.size() == 0) begin
        if (bus.rsp.rvalid === 1'b1) check("stray_rvalid", 32'(bus.rsp.rvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid", 32'(bus.rsp.rvalid), 32'(e.rvalid));
        if (e.rvalid) begin
          check("rid", 32'(bus.rsp.r.rid), 32'(e.rid));
          check("err", 32'(bus.rsp.r.err), 32'(e.err));
          if (e.chk_rdata) check("rdata", bus.rsp.r.rdata, e.rdata);
        end
        check("start_o", 32'(start_o), 32'(e.start));
        check("irq_o", 32'(irq_o), 32'(e.irq));
        check("cfg_addr_o", cfg_addr_o, e.cfg_addr);
        check("cfg_len_o", 32'(cfg_len_o), 32'(e.cfg_len));
      end
    end
  end

  initial begin : driver
    logic [31:0] a, w;
    rst_i   = 1'b1;
    bus.req = '0;
    done_i  = 1'b0;
    match_i = 1'b0;
    m_edge  = 0;
    model_reset();

    reset_cycles(3);
    idle(1);

    // Base/length programming, back-to-back with rid echo; high address bits ignored.
    wr(32'h08, 32'h1000_0003);
    wr(32'h0C, 32'd8);
    rd(32'h08);
    rd(32'hFFFF_FF0C);

    // Single run of ten cycles with interrupt enabled.
    wr(32'h00, 32'h2);
    wr(32'h00, 32'h3);
    idle(9);
    idle(1, 1, 1);
    rd(32'h04); rd(32'h14); rd(32'h10);

    // START while busy, then clear OVERRUN.
    wr(32'h00, 32'h1);
    wr(32'h00, 32'h1);
    rd(32'h04);
    wr(32'h04, 32'h8);
    rd(32'h04);

    // Completion coincident with a new START.
    idle(3);
    wr(32'h00, 32'h1, 4'hF, 1, 0);
    rd(32'h04); rd(32'h10);
    idle(2, 1, 1);

    // Reserved offsets and a single-byte LEN write.
    rd(32'h18);
    wr(32'h1C, 32'hFFFF_FFFF);
    wr(32'h0C, 32'h0000_AB00, 4'b0010);
    rd(32'h0C); rd(32'h04);

    // Zero-length START completes immediately without a run.
    wr(32'h0C, 32'h0);
    wr(32'h04, 32'hA);
    wr(32'h00, 32'h3);
    rd(32'h04); rd(32'h10);

    // DONE clear coincident with completion.
    wr(32'h0C, 32'h5);
    wr(32'h00, 32'h3);
    idle(2);
    wr(32'h04, 32'h2, 4'hF, 1, 1);
    rd(32'h04);

    // Reset mid-run with a request pending; later done_i is ignored.
    wr(32'h00, 32'h3);
    idle(3);
    step(1, 1, 0, 32'h04, '0, 4'hF, 0, 0);
    idle(3, 1, 1);
    rd(32'h04); rd(32'h10); rd(32'h08);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      a      = $urandom();
      a[4:2] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a[4:2] = 3'd3;
      w = $urandom();
      if (a[4:2] == 3'd3) w = $urandom_range(0, 3);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           a, w, 4'($urandom()), $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end

    idle(2);
    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accel_ctrl_regs.md
ACCEL_CTRL_REGS -- requirements
Module: accel_ctrl_regs

Interface
REQ-001 SHALL have parameter obi_req_t, default sbr_obi_req_t, OBI subordinate request type.
REQ-002 SHALL have parameter obi_rsp_t, default sbr_obi_rsp_t, OBI subordinate response type.
REQ-003 SHALL have parameter CycleCntWidth, default 32, width of run-cycle counter (1..32).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 obi_req_i  in  obi_req_t  req, a.addr, a.we, a.be, a.wdata, a.aid.
REQ-007 obi_rsp_o  out  obi_rsp_t  gnt, rvalid, r.rdata, r.rid, r.err.
REQ-008 start_o  out  1  one-cycle start pulse to accelerator.
REQ-009 cfg_addr_o  out  32  SRAM base address for accelerator, word-aligned.
REQ-010 cfg_len_o  out  16  word count for accelerator.
REQ-011 done_i  in  1  one-cycle completion pulse from accelerator.
REQ-012 match_i  in  1  result flag, valid only when done_i=1.
REQ-013 irq_o  out  1  level interrupt to core.

Function
REQ-014 gnt SHALL be 1 every cycle; request accepted when req=1.
REQ-015 rvalid SHALL assert exactly one cycle after each accepted request, r.rid = accepted a.aid; back-to-back requests SHALL get back-to-back responses.
REQ-016 Decode on a.addr[4:2]; a.addr[1:0] and bits above [4] ignored.
REQ-017 0x00 CTRL: bit0 START write-1 (reads 0); bit1 IRQ_EN rw.
REQ-018 0x04 STATUS: bit0 BUSY ro; bit1 DONE, bit2 MATCH, bit3 OVERRUN sticky; writing 1 to bit1 clears DONE and MATCH; writing 1 to bit3 clears OVERRUN.
REQ-019 0x08 BASE rw, bits[1:0] forced 0; 0x0C LEN rw bits[15:0], [31:16] read 0.
REQ-020 0x10 RUNS ro 16-bit completed-run count, wraps 0xFFFF->0; 0x14 CYCLES ro cycles of last run, zero-extended.
REQ-021 rw registers SHALL honour a.be per byte; ro fields ignore writes.
REQ-022 Offsets 0x18/0x1C: r.err=1, r.rdata=0xBADCAB1E, no state change; all mapped accesses r.err=0.
REQ-023 START with BUSY=0, LEN!=0: start_o=1 next cycle, BUSY=1 same edge, cycle counter cleared to 0.
REQ-024 START with BUSY=0, LEN=0: no start_o; DONE=1, MATCH=0 next cycle; RUNS unchanged.
REQ-025 START with BUSY=1: ignored, OVERRUN=1.
REQ-026 Cycle counter SHALL increment each cycle BUSY=1, saturating at all-ones.
REQ-027 done_i with BUSY=1: BUSY=0, DONE=1, MATCH=match_i, CYCLES=counter+1 (saturated), RUNS+1.
REQ-028 done_i with BUSY=0: ignored entirely.
REQ-029 done_i and START write same cycle: completion applied, then new start accepted (BUSY stays 1, start_o next cycle, no OVERRUN).
REQ-030 done_i and W1C of DONE same cycle: set wins.
REQ-031 Writes to BASE/LEN while BUSY=1 SHALL update immediately (software responsibility).
REQ-032 irq_o SHALL equal IRQ_EN & DONE, registered-free (combinational from flops).

Reset
REQ-033 On rst_i=1: all registers, counters, BUSY, DONE, MATCH, OVERRUN, IRQ_EN = 0.
REQ-034 During/after reset: rvalid=0, start_o=0, irq_o=0, cfg_addr_o=0, cfg_len_o=0; pending response dropped; reset mid-run aborts run without DONE.

Structure
REQ-035 Register offsets, field bit positions and 0xBADCAB1E constant SHALL live in user_pkg.
REQ-036 One sub-module accel_run_ctrl SHALL hold BUSY, cycle counter, RUNS and completion logic; register/OBI decode stays in top.

Verification
REQ-037 Write BASE=0x1000_0003, LEN=8 -> read BASE=0x1000_0000, LEN=8, responses one cycle after req, rid echoed.
REQ-038 START, done_i with match_i=1 after 10 cycles -> one start_o pulse, STATUS=0x6, CYCLES=10, RUNS=1, irq_o=1 iff IRQ_EN=1.
REQ-039 START while BUSY -> single start_o, STATUS bit3=1; W1C 0x8 -> bit3=0.
REQ-040 done_i coincident with START write -> DONE=1, BUSY=1, second start_o, RUNS=1, no OVERRUN.
REQ-041 Read 0x18 -> err=1, rdata=0xBADCAB1E; byte write be=0b0010 0xAB00 to LEN -> only LEN[15:8] changes.
REQ-042 rst_i asserted mid-run -> all outputs 0 next cycle, later done_i ignored.
